// File: rtl/mine_move_pkg.sv
// Shared types and screen constants for the patrolling mine mover.
package mine_move_pkg;

    // Controller states; one frame of motion walks MOVE -> CHANGE -> LIMITS.
    typedef enum logic [2:0] {
        IDLE_ST,
        MOVE_ST,
        CHANGE_ST,
        LIMITS_ST,
        PAUSE_ST
    } move_state_e;

    // Fractional bits of the fixed-point position/velocity.
    localparam int FP_SHIFT_DEFAULT = 6;

    // Play area and object size (pixels).
    localparam int SCREEN_W     = 512;
    localparam int SCREEN_H     = 480;
    localparam int OBJ_W        = 64;
    localparam int OBJ_H        = 64;
    localparam int FRAME_MARGIN = 32;

    // Default legal top-left range keeps the whole object inside the play area.
    localparam int DEF_LEFT   = FRAME_MARGIN;
    localparam int DEF_RIGHT  = SCREEN_W - OBJ_W;
    localparam int DEF_TOP    = FRAME_MARGIN;
    localparam int DEF_BOTTOM = SCREEN_H - OBJ_H;

endpackage

// File: rtl/mine_axis_limit.sv
// Per-axis clamp: pins a fixed-point position into [low, high] and turns the
// velocity inward when a wall is crossed. Purely combinational.
module mine_axis_limit
    import mine_move_pkg::*;
(
    input  logic signed [31:0] pos_i,
    input  logic signed [31:0] speed_i,
    input  logic signed [31:0] low_i,
    input  logic signed [31:0] high_i,
    output logic signed [31:0] pos_o,
    output logic signed [31:0] speed_o,
    output logic               hit_o
);

    // Clamp and reflect only a velocity that still points outward.
    always_comb begin
        pos_o   = pos_i;
        speed_o = speed_i;
        hit_o   = 1'b0;
        if (pos_i < low_i) begin
            pos_o = low_i;
            hit_o = 1'b1;
            if (speed_i < 0) begin
                speed_o = -speed_i;
            end
        end else if (pos_i > high_i) begin
            pos_o = high_i;
            hit_o = 1'b1;
            if (speed_i > 0) begin
                speed_o = -speed_i;
            end
        end
    end

endmodule

// File: rtl/mine_patrol_move.sv
// Two-axis bouncing hazard mover with collision reversal, wall dwell and freeze.
module mine_patrol_move
    import mine_move_pkg::*;
#(
    parameter int INITIAL_X         = 256,
    parameter int INITIAL_Y         = 256,
    parameter int INITIAL_X_SPEED   = 0,
    parameter int INITIAL_Y_SPEED   = 40,
    parameter int FRAME_LEFT        = DEF_LEFT,
    parameter int FRAME_RIGHT       = DEF_RIGHT,
    parameter int FRAME_TOP         = DEF_TOP,
    parameter int FRAME_BOTTOM      = DEF_BOTTOM,
    parameter int FIXED_POINT_SHIFT = FP_SHIFT_DEFAULT,
    parameter int PAUSE_FRAMES      = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               enable,
    input  logic               collision,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               moving,
    output logic               wallHit
);

    localparam logic signed [31:0] X_RST   = 32'(INITIAL_X <<< FIXED_POINT_SHIFT);
    localparam logic signed [31:0] Y_RST   = 32'(INITIAL_Y <<< FIXED_POINT_SHIFT);
    localparam logic signed [31:0] XS_RST  = 32'(INITIAL_X_SPEED);
    localparam logic signed [31:0] YS_RST  = 32'(INITIAL_Y_SPEED);
    localparam logic signed [31:0] X_LOW   = 32'(FRAME_LEFT <<< FIXED_POINT_SHIFT);
    localparam logic signed [31:0] X_HIGH  = 32'(FRAME_RIGHT <<< FIXED_POINT_SHIFT);
    localparam logic signed [31:0] Y_LOW   = 32'(FRAME_TOP <<< FIXED_POINT_SHIFT);
    localparam logic signed [31:0] Y_HIGH  = 32'(FRAME_BOTTOM <<< FIXED_POINT_SHIFT);
    localparam logic signed [10:0] X_PIX   = 11'(INITIAL_X);
    localparam logic signed [10:0] Y_PIX   = 11'(INITIAL_Y);
    localparam logic [7:0]         PAUSE_N = 8'(PAUSE_FRAMES);
    localparam logic               PAUSE_EN = (PAUSE_FRAMES > 0);

    move_state_e        state_q, state_d;
    logic signed [31:0] xpos_q, xpos_d, ypos_q, ypos_d;
    logic signed [31:0] xspd_q, xspd_d, yspd_q, yspd_d;
    logic               coll_q, coll_d;
    logic [7:0]         cnt_q, cnt_d;
    logic signed [10:0] tlx_q, tlx_d, tly_q, tly_d;
    logic               wall_q, wall_d;

    logic signed [31:0] xs_eff, ys_eff;
    logic signed [31:0] x_clamp, y_clamp, x_spd_new, y_spd_new;
    logic               x_hit, y_hit;

    mine_axis_limit u_x_limit (
        .pos_i   (xpos_q),
        .speed_i (xspd_q),
        .low_i   (X_LOW),
        .high_i  (X_HIGH),
        .pos_o   (x_clamp),
        .speed_o (x_spd_new),
        .hit_o   (x_hit)
    );

    mine_axis_limit u_y_limit (
        .pos_i   (ypos_q),
        .speed_i (yspd_q),
        .low_i   (Y_LOW),
        .high_i  (Y_HIGH),
        .pos_o   (y_clamp),
        .speed_o (y_spd_new),
        .hit_o   (y_hit)
    );

    // State register and motion datapath, asynchronously forced to reset values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE_ST;
            xpos_q  <= X_RST;
            ypos_q  <= Y_RST;
            xspd_q  <= XS_RST;
            yspd_q  <= YS_RST;
            coll_q  <= 1'b0;
            cnt_q   <= '0;
            tlx_q   <= X_PIX;
            tly_q   <= Y_PIX;
            wall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            xspd_q  <= xspd_d;
            yspd_q  <= yspd_d;
            coll_q  <= coll_d;
            cnt_q   <= cnt_d;
            tlx_q   <= tlx_d;
            tly_q   <= tly_d;
            wall_q  <= wall_d;
        end
    end

    // Next-state and datapath update for each controller state.
    always_comb begin
        state_d = state_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        xspd_d  = xspd_q;
        yspd_d  = yspd_q;
        coll_d  = coll_q;
        cnt_d   = cnt_q;
        tlx_d   = tlx_q;
        tly_d   = tly_q;
        wall_d  = 1'b0;
        xs_eff  = xspd_q;
        ys_eff  = yspd_q;
        case (state_q)
            IDLE_ST: begin
                if (startOfFrame) begin
                    state_d = MOVE_ST;
                end
            end
            MOVE_ST: begin
                if (enable && collision) begin
                    coll_d = 1'b1;
                end
                if (enable && startOfFrame) begin
                    state_d = CHANGE_ST;
                end
            end
            CHANGE_ST: begin
                // Reversal is folded in before the add so the clamp sees the
                // already-reversed velocity and never flips it back.
                if (coll_q) begin
                    xs_eff = -xspd_q;
                    ys_eff = -yspd_q;
                end
                xspd_d  = xs_eff;
                yspd_d  = ys_eff;
                xpos_d  = xpos_q + xs_eff;
                ypos_d  = ypos_q + ys_eff;
                coll_d  = 1'b0;
                state_d = LIMITS_ST;
            end
            LIMITS_ST: begin
                xpos_d = x_clamp;
                ypos_d = y_clamp;
                xspd_d = x_spd_new;
                yspd_d = y_spd_new;
                wall_d = x_hit | y_hit;
                tlx_d  = 11'(x_clamp >>> FIXED_POINT_SHIFT);
                tly_d  = 11'(y_clamp >>> FIXED_POINT_SHIFT);
                if ((x_hit || y_hit) && PAUSE_EN) begin
                    cnt_d   = PAUSE_N;
                    state_d = PAUSE_ST;
                end else begin
                    state_d = MOVE_ST;
                end
            end
            PAUSE_ST: begin
                coll_d = 1'b0;
                if (enable && startOfFrame) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = MOVE_ST;
                    end
                end
            end
            default: begin
                state_d = IDLE_ST;
            end
        endcase
    end

    assign topLeftX = tlx_q;
    assign topLeftY = tly_q;
    assign wallHit  = wall_q;
    assign moving   = (state_q == MOVE_ST) && enable;

endmodule

// File: tb/tb_mine_patrol_move.sv
// Directed bench: four parameterisations driven from shared stimulus.
module tb_mine_patrol_move;

    logic clk = 1'b0;
    logic reset, sof, enable, collision;

    logic signed [10:0] x_def, y_def, x_wall, y_wall, x_pau, y_pau, x_col, y_col;
    logic mv_def, mv_wall, mv_pau, mv_col;
    logic wh_def, wh_wall, wh_pau, wh_col;

    int n_cmp = 0;
    int n_bad = 0;
    int c_def, c_wall, c_pau, c_col;
    int def_total;

    always #5 clk = ~clk;

    mine_patrol_move u_def (
        .clk(clk), .reset(reset), .startOfFrame(sof), .enable(enable), .collision(collision),
        .topLeftX(x_def), .topLeftY(y_def), .moving(mv_def), .wallHit(wh_def)
    );

    mine_patrol_move #(.INITIAL_Y(400), .INITIAL_Y_SPEED(640)) u_wall (
        .clk(clk), .reset(reset), .startOfFrame(sof), .enable(enable), .collision(collision),
        .topLeftX(x_wall), .topLeftY(y_wall), .moving(mv_wall), .wallHit(wh_wall)
    );

    mine_patrol_move #(.INITIAL_Y(400), .INITIAL_Y_SPEED(640), .PAUSE_FRAMES(3)) u_pau (
        .clk(clk), .reset(reset), .startOfFrame(sof), .enable(enable), .collision(collision),
        .topLeftX(x_pau), .topLeftY(y_pau), .moving(mv_pau), .wallHit(wh_pau)
    );

    mine_patrol_move #(.INITIAL_Y(300), .INITIAL_Y_SPEED(640)) u_col (
        .clk(clk), .reset(reset), .startOfFrame(sof), .enable(enable), .collision(collision),
        .topLeftX(x_col), .topLeftY(y_col), .moving(mv_col), .wallHit(wh_col)
    );

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // One frame pulse followed by enough cycles for the result to reach the outputs;
    // wallHit cycles are counted per instance.
    task automatic frame();
        c_def = 0; c_wall = 0; c_pau = 0; c_col = 0;
        @(negedge clk);
        sof = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) sof = 1'b0;
            c_def  += int'(wh_def);
            c_wall += int'(wh_wall);
            c_pau  += int'(wh_pau);
            c_col  += int'(wh_col);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (x_def !== 11'sd256) begin n_bad++; $display("FAIL reset_x_def: got %0d want 256", x_def); end
        n_cmp++; if (y_def !== 11'sd256) begin n_bad++; $display("FAIL reset_y_def: got %0d want 256", y_def); end
        n_cmp++; if (mv_def !== 1'b0) begin n_bad++; $display("FAIL reset_moving: got %b want 0", mv_def); end
        n_cmp++; if (wh_def !== 1'b0) begin n_bad++; $display("FAIL reset_wallhit: got %b want 0", wh_def); end
        n_cmp++; if (y_wall !== 11'sd400) begin n_bad++; $display("FAIL reset_y_wall: got %0d want 400", y_wall); end
    endtask

    task automatic test_free_run();
        do_reset();
        def_total = 0;
        frame();
        def_total += c_def;
        n_cmp++; if (y_def !== 11'sd256) begin n_bad++; $display("FAIL idle_frame_y: got %0d want 256", y_def); end
        n_cmp++; if (mv_def !== 1'b1) begin n_bad++; $display("FAIL free_moving: got %b want 1", mv_def); end
        for (int k = 1; k <= 16; k++) begin
            frame();
            def_total += c_def;
            if (k == 8) begin
                n_cmp++; if (y_def !== 11'sd261) begin n_bad++; $display("FAIL free_y8: got %0d want 261", y_def); end
            end
        end
        n_cmp++; if (y_def !== 11'sd266) begin n_bad++; $display("FAIL free_y16: got %0d want 266", y_def); end
        n_cmp++; if (x_def !== 11'sd256) begin n_bad++; $display("FAIL free_x16: got %0d want 256", x_def); end
        n_cmp++; if (def_total !== 0) begin n_bad++; $display("FAIL free_wallhit: got %0d pulses want 0", def_total); end
    endtask

    task automatic test_wall_bounce();
        do_reset();
        frame();
        frame();
        n_cmp++; if (y_wall !== 11'sd410) begin n_bad++; $display("FAIL wall_f1: got %0d want 410", y_wall); end
        n_cmp++; if (c_wall !== 0) begin n_bad++; $display("FAIL wall_f1_hit: got %0d want 0", c_wall); end
        frame();
        n_cmp++; if (y_wall !== 11'sd416) begin n_bad++; $display("FAIL wall_f2: got %0d want 416", y_wall); end
        n_cmp++; if (c_wall !== 1) begin n_bad++; $display("FAIL wall_f2_hit: got %0d cycles want 1", c_wall); end
        frame();
        n_cmp++; if (y_wall !== 11'sd406) begin n_bad++; $display("FAIL wall_f3: got %0d want 406", y_wall); end
        frame();
        n_cmp++; if (y_wall !== 11'sd396) begin n_bad++; $display("FAIL wall_f4: got %0d want 396", y_wall); end
    endtask

    task automatic test_pause();
        do_reset();
        frame();
        frame();
        frame();
        n_cmp++; if (y_pau !== 11'sd416) begin n_bad++; $display("FAIL pause_hit_y: got %0d want 416", y_pau); end
        n_cmp++; if (c_pau !== 1) begin n_bad++; $display("FAIL pause_hit: got %0d cycles want 1", c_pau); end
        n_cmp++; if (mv_pau !== 1'b0) begin n_bad++; $display("FAIL pause_mv0: got %b want 0", mv_pau); end
        for (int k = 1; k <= 3; k++) begin
            frame();
            n_cmp++; if (y_pau !== 11'sd416) begin n_bad++; $display("FAIL pause_hold%0d: got %0d want 416", k, y_pau); end
            if (k < 3) begin
                n_cmp++; if (mv_pau !== 1'b0) begin n_bad++; $display("FAIL pause_mv%0d: got %b want 0", k, mv_pau); end
            end
        end
        n_cmp++; if (mv_pau !== 1'b1) begin n_bad++; $display("FAIL pause_resume_mv: got %b want 1", mv_pau); end
        frame();
        n_cmp++; if (y_pau !== 11'sd406) begin n_bad++; $display("FAIL pause_after: got %0d want 406", y_pau); end
    endtask

    task automatic test_collision();
        do_reset();
        frame();
        @(negedge clk); collision = 1'b1;
        @(negedge clk); collision = 1'b0;
        @(negedge clk); collision = 1'b1;
        @(negedge clk); collision = 1'b0;
        n_cmp++; if (y_col !== 11'sd300) begin n_bad++; $display("FAIL coll_pre: got %0d want 300", y_col); end
        frame();
        n_cmp++; if (y_col !== 11'sd290) begin n_bad++; $display("FAIL coll_f1: got %0d want 290", y_col); end
        frame();
        n_cmp++; if (y_col !== 11'sd280) begin n_bad++; $display("FAIL coll_f2: got %0d want 280", y_col); end
    endtask

    task automatic test_enable();
        do_reset();
        frame();
        enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (mv_col !== 1'b0) begin n_bad++; $display("FAIL en_moving0: got %b want 0", mv_col); end
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                @(negedge clk); collision = 1'b1;
                @(negedge clk); collision = 1'b0;
            end
            frame();
        end
        n_cmp++; if (y_col !== 11'sd300) begin n_bad++; $display("FAIL en_frozen: got %0d want 300", y_col); end
        enable = 1'b1;
        @(negedge clk);
        n_cmp++; if (mv_col !== 1'b1) begin n_bad++; $display("FAIL en_moving1: got %b want 1", mv_col); end
        frame();
        n_cmp++; if (y_col !== 11'sd310) begin n_bad++; $display("FAIL en_resume: got %0d want 310", y_col); end
    endtask

    task automatic test_reset_mid();
        int hits;
        do_reset();
        frame();
        frame();
        // Start the frame that would clamp at 416, then reset while in LIMITS_ST.
        @(negedge clk); sof = 1'b1;
        @(negedge clk); sof = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (y_wall !== 11'sd400) begin n_bad++; $display("FAIL rmid_y: got %0d want 400", y_wall); end
        n_cmp++; if (x_wall !== 11'sd256) begin n_bad++; $display("FAIL rmid_x: got %0d want 256", x_wall); end
        n_cmp++; if (y_def !== 11'sd256) begin n_bad++; $display("FAIL rmid_ydef: got %0d want 256", y_def); end
        n_cmp++; if (mv_wall !== 1'b0) begin n_bad++; $display("FAIL rmid_moving: got %b want 0", mv_wall); end
        hits = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            hits += int'(wh_wall);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            hits += int'(wh_wall);
        end
        n_cmp++; if (hits !== 0) begin n_bad++; $display("FAIL rmid_wallhit: got %0d cycles want 0", hits); end
        n_cmp++; if (y_wall !== 11'sd400) begin n_bad++; $display("FAIL rmid_after: got %0d want 400", y_wall); end
    endtask

    initial begin
        reset = 1'b1;
        sof = 1'b0;
        enable = 1'b1;
        collision = 1'b0;
        test_reset();
        test_free_run();
        test_wall_bounce();
        test_pause();
        test_collision();
        test_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
        $fatal(1);
    end

endmodule
